trojan_scan_ctrl: RTL

TROJAN_SCAN_CTRL -- requirements
Module: trojan_scan_ctrl

---
 rtl/trojan_scan_pkg.sv | 19 +
 rtl/golden_ref_model.sv | 17 +
 rtl/trojan_scan_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/trojan_scan_pkg.sv
// Shared types and sizing for the exhaustive 3-input trojan scan controller.
package trojan_scan_pkg;

  localparam int unsigned NUM_PATTERNS = 8;
  localparam int unsigned IDX_W        = 3;
  localparam int unsigned CNT_W        = 4;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

endpackage

// File: rtl/golden_ref_model.sv
// Combinational reference for the circuit-under-test: expected E/F/G/H for inputs A/B/C.
module golden_ref_model (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic e,
  output logic f,
  output logic g,
  output logic h
);

  assign e = a & b;
  assign f = a | c;
  assign g = ~c;
  assign h = ((a & b) | ((a | c) & ~c)) & c;

endmodule

// File: rtl/trojan_scan_ctrl.sv
// Walks all 8 input patterns through the CUT, compares each settled response
// with the golden model and accumulates a per-pattern mismatch summary.
module trojan_scan_ctrl
  import trojan_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             cut_a,
  output logic             cut_b,
  output logic             cut_c,
  input  logic             cut_e,
  input  logic             cut_f,
  input  logic             cut_g,
  input  logic             cut_h,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [7:0]       fail_mask,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [IDX_W-1:0] first_fail
);

  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam idx_t       IDX_LAST    = idx_t'(NUM_PATTERNS - 1);

  state_e     state_q, state_d;
  idx_t       idx_q, idx_d;
  logic [3:0] settle_q, settle_d;
  logic [7:0] mask_q, mask_d;
  cnt_t       count_q, count_d;
  idx_t       first_q, first_d;

  logic gold_e, gold_f, gold_g, gold_h;
  logic mismatch;
  logic abort_hit;
  logic start_hit;

  golden_ref_model u_golden (
    .a (idx_q[2]),
    .b (idx_q[1]),
    .c (idx_q[0]),
    .e (gold_e),
    .f (gold_f),
    .g (gold_g),
    .h (gold_h)
  );

  assign mismatch  = {cut_e, cut_f, cut_g, cut_h} != {gold_e, gold_f, gold_g, gold_h};
  assign abort_hit = abort && (state_q != ST_IDLE);
  assign start_hit = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_APPLY;
      ST_APPLY:  state_d = abort ? ST_IDLE : ((SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE);
      ST_SETTLE: begin
        if (abort)                        state_d = ST_IDLE;
        else if (settle_q == SETTLE_LAST) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (abort)                 state_d = ST_IDLE;
        else if (idx_q == IDX_LAST) state_d = ST_DONE;
        else                       state_d = ST_APPLY;
      end
      ST_DONE: begin
        if (abort)      state_d = ST_IDLE;
        else if (start) state_d = ST_APPLY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      settle_q <= '0;
      mask_q   <= '0;
      count_q  <= '0;
      first_q  <= '0;
    end else begin
      idx_q    <= idx_d;
      settle_q <= settle_d;
      mask_q   <= mask_d;
      count_q  <= count_d;
      first_q  <= first_d;
    end
  end

  // Abort discards any mismatch seen in the same CHECK cycle.
  always_comb begin
    idx_d    = idx_q;
    settle_d = settle_q;
    mask_d   = mask_q;
    count_d  = count_q;
    first_d  = first_q;
    if (abort_hit || start_hit) begin
      idx_d    = '0;
      settle_d = '0;
      mask_d   = '0;
      count_d  = '0;
      first_d  = '0;
    end else begin
      unique case (state_q)
        ST_APPLY:  settle_d = '0;
        ST_SETTLE: settle_d = settle_q + 4'd1;
        ST_CHECK: begin
          if (mismatch) begin
            mask_d[idx_q] = 1'b1;
            count_d       = count_q + cnt_t'(1);
            if (count_q == '0) first_d = idx_q;
          end
          if (idx_q != IDX_LAST) idx_d = idx_q + idx_t'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    done = (state_q == ST_DONE);
    pass = (state_q == ST_DONE) && (count_q == '0);
    fail = (state_q == ST_DONE) && (count_q != '0);
    {cut_a, cut_b, cut_c} = busy ? idx_q : '0;
  end

  assign fail_mask      = mask_q;
  assign mismatch_count = count_q;
  assign first_fail     = first_q;

endmodule
